// File: rtl/lane_accumulator.sv
// Lane accumulator: issues LANES operands to an external pipelined kernel and sums half-operands
// plus kernel results. Define LANE_ACC_SAT_EN for a clamping accumulator with a sticky flag.
module lane_accumulator #(
  parameter int unsigned Lanes       = 2,
  parameter int unsigned DataWidth   = 22,
  parameter int unsigned AccWidth    = 32,
  parameter int unsigned MaxInflight = 16,
  parameter int unsigned NWidth      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clk_en_i,
  input  logic                       start_i,
  input  logic [NWidth-1:0]          n_i,
  input  logic [Lanes*DataWidth-1:0] x_in_i,
  output logic [AccWidth-1:0]        result_o,
  output logic                       done_o,
  output logic                       saturated_o,
  output logic                       kernel_in_valid_o,
  input  logic                       kernel_in_ready_i,
  output logic [DataWidth-1:0]       kernel_in_data_o,
  input  logic                       kernel_out_valid_i,
  input  logic [DataWidth-1:0]       kernel_out_data_i
);

  localparam int unsigned CntW  = $clog2(MaxInflight + 1);
  localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;

  localparam logic [NWidth-1:0] CmdClear = NWidth'(0);
  localparam logic [NWidth-1:0] CmdGo    = NWidth'(1);
  localparam logic [NWidth-1:0] CmdRead  = NWidth'(2);
  localparam logic [NWidth-1:0] CmdPeek  = NWidth'(3);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                     state_q, state_d;
  logic [Lanes*DataWidth-1:0] x_q, x_d;
  logic [LaneW-1:0]           lane_q, lane_d;
  logic [NWidth-1:0]          cmd_q, cmd_d;
  logic [CntW-1:0]            inflight_q, inflight_d;
  logic signed [AccWidth-1:0] acc_q, acc_d, acc_res;
  logic [AccWidth-1:0]        result_q, result_d;

  logic                        accept, issue, last_lane, drained;
  logic signed [DataWidth-1:0] lane_op, half_term, kout;

  assign accept    = (state_q == StIdle) && start_i && clk_en_i;
  assign issue     = (state_q == StIssue) && kernel_in_ready_i &&
                     (inflight_q < CntW'(MaxInflight));
  assign last_lane = (lane_q == LaneW'(Lanes - 1));
  assign drained   = (state_q == StDrain) && (inflight_q == '0);
  assign lane_op   = x_q[int'(lane_q)*DataWidth +: DataWidth];
  assign half_term = lane_op >>> 1;
  assign kout      = kernel_out_data_i;

`ifdef LANE_ACC_SAT_EN
  localparam int unsigned SumW = AccWidth + 2;
  localparam logic signed [SumW-1:0] AccMax = SumW'({1'b0, {(AccWidth-1){1'b1}}});
  localparam logic signed [SumW-1:0] AccMin = SumW'(signed'({1'b1, {(AccWidth-1){1'b0}}}));

  logic signed [SumW-1:0] sum;
  logic                   ovf, sat_q, sat_d;

  always_comb begin
    sum = SumW'(acc_q);
    if (issue)              sum = sum + SumW'(half_term);
    if (kernel_out_valid_i) sum = sum + SumW'(kout);
    ovf     = 1'b0;
    acc_res = sum[AccWidth-1:0];
    if (sum > AccMax) begin
      acc_res = AccMax[AccWidth-1:0];
      ovf     = 1'b1;
    end else if (sum < AccMin) begin
      acc_res = AccMin[AccWidth-1:0];
      ovf     = 1'b1;
    end
    sat_d = sat_q | ovf;
    if (drained && (cmd_q == CmdRead || cmd_q == CmdClear)) sat_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign saturated_o = sat_q;
`else
  // Wrapping at AccWidth gives the same bits as summing wider and truncating.
  always_comb begin
    acc_res = acc_q;
    if (issue)              acc_res = acc_res + AccWidth'(half_term);
    if (kernel_out_valid_i) acc_res = acc_res + AccWidth'(kout);
  end

  assign saturated_o = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      x_q        <= '0;
      lane_q     <= '0;
      cmd_q      <= CmdClear;
      inflight_q <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      lane_q     <= lane_d;
      cmd_q      <= cmd_d;
      inflight_q <= inflight_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (n_i == CmdGo) ? StIssue : StDrain;
      StIssue: if (issue && last_lane) state_d = StDone;
      StDrain: if (inflight_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    x_d        = x_q;
    lane_d     = lane_q;
    cmd_d      = cmd_q;
    inflight_d = inflight_q;
    acc_d      = acc_res;
    result_d   = result_q;

    if (accept) begin
      cmd_d  = n_i;
      lane_d = '0;
      if (n_i == CmdGo) x_d = x_in_i;
    end

    if (issue) lane_d = last_lane ? '0 : lane_q + LaneW'(1);

    // A return with nothing outstanding is a kernel error; the count stays at zero.
    case ({issue, kernel_out_valid_i})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (issue && last_lane) result_d = '0;

    if (drained) begin
      if (cmd_q == CmdRead || cmd_q == CmdPeek) result_d = acc_q;
      else                                      result_d = '0;
      if (cmd_q == CmdRead || cmd_q == CmdClear) acc_d = '0;
    end
  end

  // Outputs
  always_comb begin
    done_o            = (state_q == StDone);
    kernel_in_valid_o = issue;
    kernel_in_data_o  = issue ? lane_op : '0;
    result_o          = result_q;
  end

endmodule

// File: tb/tb_lane_accumulator.sv
// Directed bench for lane_accumulator: three configurations, each driven by a fixed-latency
// constant-output kernel stub. Expectations for the 24-bit case follow LANE_ACC_SAT_EN.
module tb_lane_accumulator;

  localparam logic [1:0] Clear = 2'd0, Go = 2'd1, Read = 2'd2, Peek = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [1:0]  n = 2'd0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [21:0] kd = '0;

  logic [43:0] x_a = '0, x_c = '0;
  logic [87:0] x_b = '0;

  logic [31:0] result_a, result_b;
  logic [23:0] result_c;
  logic        done_a, done_b, done_c, sat_a, sat_b, sat_c;
  logic        kv_a, kv_b, kv_c, kov_a, kov_b, kov_c;
  logic [21:0] kdi_a, kdi_b, kdi_c;

  logic [3:0] pipe_a = '0, pipe_c = '0;
  logic [5:0] pipe_b = '0;

  int n_cmp = 0, n_err = 0;
  int cnt_b = 0, peak_b = 0, viol_b = 0;
  int lat;

  always #5 clk = ~clk;

  lane_accumulator #(.Lanes(2), .DataWidth(22), .AccWidth(32), .MaxInflight(16), .NWidth(2)) u_a (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .start_i(start_a), .n_i(n), .x_in_i(x_a),
    .result_o(result_a), .done_o(done_a), .saturated_o(sat_a), .kernel_in_valid_o(kv_a),
    .kernel_in_ready_i(1'b1), .kernel_in_data_o(kdi_a), .kernel_out_valid_i(kov_a),
    .kernel_out_data_i(kd)
  );

  lane_accumulator #(.Lanes(4), .DataWidth(22), .AccWidth(32), .MaxInflight(2), .NWidth(2)) u_b (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .start_i(start_b), .n_i(n), .x_in_i(x_b),
    .result_o(result_b), .done_o(done_b), .saturated_o(sat_b), .kernel_in_valid_o(kv_b),
    .kernel_in_ready_i(1'b1), .kernel_in_data_o(kdi_b), .kernel_out_valid_i(kov_b),
    .kernel_out_data_i(kd)
  );

  lane_accumulator #(.Lanes(2), .DataWidth(22), .AccWidth(24), .MaxInflight(16), .NWidth(2)) u_c (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .start_i(start_c), .n_i(n), .x_in_i(x_c),
    .result_o(result_c), .done_o(done_c), .saturated_o(sat_c), .kernel_in_valid_o(kv_c),
    .kernel_in_ready_i(1'b1), .kernel_in_data_o(kdi_c), .kernel_out_valid_i(kov_c),
    .kernel_out_data_i(kd)
  );

  // Kernel stubs: result appears Latency cycles after the issue cycle, flushed by rst.
  always @(posedge clk) begin
    if (rst) begin
      pipe_a <= '0; pipe_b <= '0; pipe_c <= '0; cnt_b <= 0;
    end else begin
      pipe_a <= {pipe_a[2:0], kv_a};
      pipe_b <= {pipe_b[4:0], kv_b};
      pipe_c <= {pipe_c[2:0], kv_c};
      if (kv_b && cnt_b >= 2) viol_b <= viol_b + 1;
      if (cnt_b > peak_b) peak_b <= cnt_b;
      cnt_b <= cnt_b + int'(kv_b) - int'(kov_b);
    end
  end
  assign kov_a = pipe_a[3];
  assign kov_b = pipe_b[5];
  assign kov_c = pipe_c[3];

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic done_sel(input int inst);
    case (inst)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Pulses start for one cycle and returns cycles from the start cycle to done.
  task automatic run_cmd(input string tag, input int inst, input logic [1:0] cmd,
                         output int cycles);
    @(negedge clk);
    n = cmd;
    case (inst)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cycles = 1;
    while (!done_sel(inst) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check_eq({tag, "_done"}, done_sel(inst), 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_result", $signed(result_a), 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_kvalid", kv_a, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_sat", sat_a, 0);
    check_eq("idle_kvalid", kv_a, 0);

    // Basic GO then READ: 128+128+1000+1000.
    kd  = 22'd1000;
    x_a = {22'd256, 22'd256};
    run_cmd("go1", 0, Go, lat);
    check_eq("go1_lat", lat, 3);
    check_eq("go1_result", $signed(result_a), 0);
    run_cmd("rd1", 0, Read, lat);
    check_eq("rd1_lat", lat, 4);
    check_eq("rd1_result", $signed(result_a), 2256);
    run_cmd("rd2", 0, Read, lat);
    check_eq("rd2_lat", lat, 2);
    check_eq("rd2_result", $signed(result_a), 0);

    // Negative operands, non-destructive PEEK: (-3>>>1)+(-5>>>1) = -2 + -3.
    kd  = '0;
    x_a = {-22'sd5, -22'sd3};
    run_cmd("go2", 0, Go, lat);
    run_cmd("pk1", 0, Peek, lat);
    check_eq("pk1_result", $signed(result_a), -5);
    run_cmd("pk2", 0, Peek, lat);
    check_eq("pk2_result", $signed(result_a), -5);
    check_eq("pk2_sat", sat_a, 0);
    run_cmd("rd3", 0, Read, lat);
    check_eq("rd3_result", $signed(result_a), -5);

    // CLEAR issued with both kernel results still outstanding.
    kd  = 22'd77;
    x_a = {22'd4, 22'd2};
    run_cmd("go3", 0, Go, lat);
    run_cmd("clr", 0, Clear, lat);
    check_eq("clr_lat", lat, 4);
    check_eq("clr_result", $signed(result_a), 0);
    run_cmd("rd4", 0, Read, lat);
    check_eq("rd4_result", $signed(result_a), 0);

    // Leave a nonzero result, then reset mid-ISSUE on lane 1.
    kd  = '0;
    x_a = {22'd100, 22'd100};
    run_cmd("go4", 0, Go, lat);
    run_cmd("pk3", 0, Peek, lat);
    check_eq("pk3_result", $signed(result_a), 100);
    x_a = {22'd6, 22'd6};
    @(negedge clk);
    n = Go; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_kvalid", kv_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_done", done_a, 0);
    check_eq("mid_rst_result", $signed(result_a), 0);
    check_eq("mid_rst_kvalid", kv_a, 0);
    check_eq("mid_rst_kdata", kdi_a, 0);
    @(negedge clk);
    check_eq("post_rst_done", done_a, 0);
    kd  = 22'd1000;
    x_a = {22'd256, 22'd256};
    run_cmd("go5", 0, Go, lat);
    check_eq("go5_lat", lat, 3);
    run_cmd("rd5", 0, Read, lat);
    check_eq("rd5_result", $signed(result_a), 2256);

    // Four lanes, two credits, six-cycle kernel: stalls cycles 3..7, done at start+10.
    kd  = 22'd100;
    x_b = {22'd40, 22'd30, 22'd20, 22'd10};
    run_cmd("gob", 1, Go, lat);
    check_eq("gob_lat", lat, 10);
    run_cmd("rdb", 1, Read, lat);
    check_eq("rdb_result", $signed(result_b), 450);
    check_eq("b_credit_viol", viol_b, 0);
    check_eq("b_peak_inflight", peak_b, 2);

    // 24-bit accumulator pushed past +max by two GOs (total 12582904).
    kd  = 22'h1FFFFF;
    x_c = {22'h1FFFFF, 22'h1FFFFF};
    run_cmd("goc1", 2, Go, lat);
    run_cmd("goc2", 2, Go, lat);
    run_cmd("pkc", 2, Peek, lat);
`ifdef LANE_ACC_SAT_EN
    check_eq("c_result", $signed(result_c), 24'sh7FFFFF);
    check_eq("c_sat", sat_c, 1);
`else
    check_eq("c_result", $signed(result_c), -4194312);
    check_eq("c_sat", sat_c, 0);
`endif
    run_cmd("rdc", 2, Read, lat);
    check_eq("c_sat_after_read", sat_c, 0);
    run_cmd("rdc2", 2, Read, lat);
    check_eq("c_result_after_read", $signed(result_c), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
